// File: rtl/game_flow_ctrl.sv
// Game flow controller: board selection, game start/reset sequencing, move
// forwarding with counters, one-second timing and win/exit handling.
module game_flow_ctrl #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  btn_act,
  input  logic        btn_ok,
  input  logic        btn_back,
  input  logic        win_flag,
  output logic [1:0]  game_status,
  output logic [11:0] origin_bd,
  output logic [3:0]  act,
  output logic        pc_reset,
  output logic [1:0]  board_idx,
  output logic [7:0]  move_cnt,
  output logic [7:0]  sec_cnt
);

  typedef enum logic [1:0] {
    CHOSE_BOARD  = 2'b00,
    GAMING       = 2'b01,
    GAME_INITIAL = 2'b10,
    WINNED       = 2'b11
  } state_t;

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [3:0]    act_prev;
  logic          ok_prev;
  logic          back_prev;

  logic [3:0]    act_edge;
  logic          ok_edge;
  logic          back_edge;
  logic          act_valid;
  logic          tick_wrap;

  assign game_status = state;

  // Previous levels reset high so a button held across reset is not an edge.
  assign act_edge  = btn_act & ~act_prev;
  assign ok_edge   = btn_ok & ~ok_prev;
  assign back_edge = btn_back & ~back_prev;
  assign act_valid = (act_edge != 4'd0) && ((act_edge & (act_edge - 4'd1)) == 4'd0);
  assign tick_wrap = (tick_cnt == TICK_LAST);

  always_comb begin
    origin_bd = 12'b001_011_000_010;
    case (board_idx)
      2'd0: origin_bd = 12'b001_011_000_010;
      2'd1: origin_bd = 12'b010_000_011_001;
      2'd2: origin_bd = 12'b011_010_001_000;
      2'd3: origin_bd = 12'b000_001_010_011;
      default: origin_bd = 12'b001_011_000_010;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= CHOSE_BOARD;
      board_idx <= 2'd0;
      move_cnt  <= 8'd0;
      sec_cnt   <= 8'd0;
      tick_cnt  <= '0;
      act       <= 4'd0;
      pc_reset  <= 1'b1;
      act_prev  <= 4'hF;
      ok_prev   <= 1'b1;
      back_prev <= 1'b1;
    end else begin
      act_prev  <= btn_act;
      ok_prev   <= btn_ok;
      back_prev <= btn_back;
      act       <= 4'd0;
      pc_reset  <= 1'b0;
      case (state)
        CHOSE_BOARD: begin
          if (act_valid && act_edge[0]) begin
            board_idx <= board_idx + 2'd1;
          end else if (act_valid && act_edge[1]) begin
            board_idx <= board_idx - 2'd1;
          end
          if (ok_edge) begin
            state    <= GAME_INITIAL;
            pc_reset <= 1'b1;
            move_cnt <= 8'd0;
            sec_cnt  <= 8'd0;
            tick_cnt <= '0;
          end
        end
        GAME_INITIAL: begin
          move_cnt <= 8'd0;
          sec_cnt  <= 8'd0;
          tick_cnt <= '0;
          state    <= GAMING;
        end
        GAMING: begin
          if (tick_wrap) begin
            tick_cnt <= '0;
            if (sec_cnt != 8'hFF) sec_cnt <= sec_cnt + 8'd1;
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
          // A win swallows any move arriving in the same cycle.
          if (win_flag) begin
            state <= WINNED;
          end else if (back_edge) begin
            state <= CHOSE_BOARD;
          end else if (act_valid) begin
            act <= act_edge;
            if (move_cnt != 8'hFF) move_cnt <= move_cnt + 8'd1;
          end
        end
        WINNED: begin
          if (ok_edge) begin
            state     <= CHOSE_BOARD;
            board_idx <= board_idx + 2'd1;
          end else if (back_edge) begin
            state    <= GAME_INITIAL;
            pc_reset <= 1'b1;
            move_cnt <= 8'd0;
            sec_cnt  <= 8'd0;
            tick_cnt <= '0;
          end
        end
        default: state <= CHOSE_BOARD;
      endcase
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed vector table, reset scenarios, counter
// saturation and randomized traffic against a behavioural game model.
module tb_game_flow_ctrl;

  localparam int TICK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  btn_act = 4'd0;
  logic        btn_ok = 1'b0;
  logic        btn_back = 1'b0;
  logic        win_flag = 1'b0;
  logic [1:0]  game_status;
  logic [11:0] origin_bd;
  logic [3:0]  act;
  logic        pc_reset;
  logic [1:0]  board_idx;
  logic [7:0]  move_cnt;
  logic [7:0]  sec_cnt;

  game_flow_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .reset(reset), .btn_act(btn_act), .btn_ok(btn_ok),
    .btn_back(btn_back), .win_flag(win_flag), .game_status(game_status),
    .origin_bd(origin_bd), .act(act), .pc_reset(pc_reset),
    .board_idx(board_idx), .move_cnt(move_cnt), .sec_cnt(sec_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [11:0] bd_tab [4];

  typedef struct {
    logic [3:0] a;
    logic       ok, back, win;
    logic [1:0] st, idx;
    logic [3:0] act;
    logic       pcr;
    logic [7:0] mv, sec;
  } vec_t;
  vec_t vecs[$];

  // ---------------- behavioural model ----------------
  typedef enum {M_SELECT, M_INIT, M_PLAY, M_WON} mode_t;
  mode_t      m_mode;
  int         m_idx, m_moves, m_play;
  logic [3:0] m_pa;
  logic       m_po, m_pb, m_pcr;
  logic [3:0] exp_q[$];

  function automatic logic [1:0] mode_code(mode_t m);
    case (m)
      M_SELECT: return 2'b00;
      M_PLAY:   return 2'b01;
      M_INIT:   return 2'b10;
      default:  return 2'b11;
    endcase
  endfunction

  function automatic logic [7:0] sat(int v);
    return (v > 255) ? 8'd255 : v[7:0];
  endfunction

  task automatic model_reset();
    m_mode = M_SELECT; m_idx = 0; m_moves = 0; m_play = 0;
    m_pa = 4'hF; m_po = 1'b1; m_pb = 1'b1; m_pcr = 1'b1;
    exp_q.delete();
  endtask

  task automatic start_game();
    m_mode = M_INIT; m_pcr = 1'b1; m_moves = 0; m_play = 0;
  endtask

  task automatic model_step(input logic [3:0] a, input logic ok, back, win);
    logic [3:0] ea, pulse;
    logic eo, eb;
    bit one;
    ea = a & ~m_pa; eo = ok & ~m_po; eb = back & ~m_pb;
    m_pa = a; m_po = ok; m_pb = back;
    one = ($countones(ea) == 1);
    pulse = 4'd0; m_pcr = 1'b0;
    case (m_mode)
      M_SELECT: begin
        if (one && ea[0]) m_idx = (m_idx + 1) % 4;
        else if (one && ea[1]) m_idx = (m_idx + 3) % 4;
        if (eo) start_game();
      end
      M_INIT: m_mode = M_PLAY;
      M_PLAY: begin
        m_play++;
        if (win) m_mode = M_WON;
        else if (eb) m_mode = M_SELECT;
        else if (one) begin pulse = ea; m_moves++; end
      end
      M_WON: begin
        if (eo) begin m_idx = (m_idx + 1) % 4; m_mode = M_SELECT; end
        else if (eb) start_game();
      end
      default: ;
    endcase
    exp_q.push_back(pulse);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic [1:0] idx,
                           input logic [3:0] a, input logic pcr, input logic [7:0] mv,
                           input logic [7:0] sec);
    chk({tag, ".status"},    12'(game_status), 12'(st));
    chk({tag, ".board_idx"}, 12'(board_idx),   12'(idx));
    chk({tag, ".origin_bd"}, origin_bd,        bd_tab[idx]);
    chk({tag, ".act"},       12'(act),         12'(a));
    chk({tag, ".pc_reset"},  12'(pc_reset),    12'(pcr));
    chk({tag, ".move_cnt"},  12'(move_cnt),    12'(mv));
    chk({tag, ".sec_cnt"},   12'(sec_cnt),     12'(sec));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input string tag, input logic [3:0] a, input logic ok,
                       input logic back, input logic win);
    logic [3:0] exp_act;
    btn_act = a; btn_ok = ok; btn_back = back; win_flag = win;
    @(posedge clk);
    model_step(a, ok, back, win);
    #1;
    exp_act = (exp_q.size() > 0) ? exp_q.pop_front() : 4'd0;
    check_all(tag, mode_code(m_mode), 2'(m_idx), exp_act, m_pcr, sat(m_moves),
              sat(m_play / TICK_DIV));
  endtask

  task automatic apply_vec(input int i, input vec_t v);
    btn_act = v.a; btn_ok = v.ok; btn_back = v.back; win_flag = v.win;
    @(posedge clk);
    model_step(v.a, v.ok, v.back, v.win);
    #1;
    exp_q.delete();
    check_all($sformatf("vec%0d", i), v.st, v.idx, v.act, v.pcr, v.mv, v.sec);
  endtask

  // Reset asserted between clock edges; outputs must change without a clock.
  task automatic do_reset(input string tag);
    #2 reset = 1'b0;
    #1 check_all(tag, 2'b00, 2'b00, 4'd0, 1'b1, 8'd0, 8'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic vec_t mk(input int a, ok, back, win, st, idx, ac, pcr, mv, sec);
    vec_t v;
    v.a = a[3:0]; v.ok = ok[0]; v.back = back[0]; v.win = win[0];
    v.st = st[1:0]; v.idx = idx[1:0]; v.act = ac[3:0]; v.pcr = pcr[0];
    v.mv = mv[7:0]; v.sec = sec[7:0];
    return v;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [3:0] ra;
    logic [3:0] one_hot;
    int r;
    bd_tab[0] = 12'b001_011_000_010;
    bd_tab[1] = 12'b010_000_011_001;
    bd_tab[2] = 12'b011_010_001_000;
    bd_tab[3] = 12'b000_001_010_011;

    //            a ok bk wn  st idx act pcr mv sec
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 3, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 0, 0));
    vecs.push_back(mk(2, 0, 0, 0, 0, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
    vecs.push_back(mk(4, 0, 0, 0, 0, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
    vecs.push_back(mk(3, 0, 0, 0, 0, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2, 2, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
    vecs.push_back(mk(4, 0, 0, 0, 1, 2, 4, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0, 1, 0));
    vecs.push_back(mk(10, 0, 0, 0, 1, 2, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0, 1, 2));
    vecs.push_back(mk(1, 0, 0, 1, 3, 2, 0, 0, 1, 2));
    vecs.push_back(mk(0, 0, 0, 1, 3, 2, 0, 0, 1, 2));
    vecs.push_back(mk(1, 0, 0, 0, 3, 2, 0, 0, 1, 2));
    vecs.push_back(mk(0, 0, 1, 0, 2, 2, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 3, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 3, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2, 3, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 3, 3, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(2, 0, 1, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    // Power-on reset
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("por", 2'b00, 2'b00, 4'd0, 1'b1, 8'd0, 8'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed table
    for (int i = 0; i < vecs.size(); i++) apply_vec(i, vecs[i]);

    // Reset mid-game with a button held through release
    cycle("rst_seq", 4'd0, 1'b1, 1'b0, 1'b0);
    cycle("rst_seq", 4'd0, 1'b0, 1'b0, 1'b0);
    cycle("rst_seq", 4'b0001, 1'b0, 1'b0, 1'b0);
    do_reset("rst_mid");
    cycle("rst_held", 4'b0001, 1'b0, 1'b0, 1'b0);
    cycle("rst_held", 4'b0001, 1'b0, 1'b0, 1'b0);
    cycle("rst_held", 4'b0000, 1'b0, 1'b0, 1'b0);

    // Move and second counters run into saturation
    cycle("sat", 4'd0, 1'b1, 1'b0, 1'b0);
    cycle("sat", 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) begin
      one_hot = 4'b0001 << $urandom_range(0, 3);
      cycle("sat_mv", one_hot, 1'b0, 1'b0, 1'b0);
      cycle("sat_mv", 4'd0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 1100; i++) cycle("sat_sec", 4'd0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic
    ra = 4'd0;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) ra = 4'd0;
      else if (r < 8) ra = 4'b0001 << $urandom_range(0, 3);
      else if (r == 8) ra = 4'($urandom_range(0, 15));
      cycle("rand", ra, ($urandom_range(0, 9) == 0), ($urandom_range(0, 14) == 0),
            ($urandom_range(0, 24) == 0));
      if (i % 700 == 350) do_reset("rand_rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
